plic_irq_axil_forwarder: RTL and testbench

- Multi-target successor to the single-target interrupt-to-AXI-lite forwarder behind the PLIC wrapper.
- Watches targets_p interrupt levels from the PLIC and issues AXI-lite master writes that mirror each level change to a per-target doorbell register.
- Addresses follow base_addr_p + t*stride_p.
- Adds round-robin arbitration, change coalescing, bounded retry on error responses, and a sticky error status.

---
 rtl/plic_irq_axil_forwarder.sv | 186 ++++++++++++++++++
 tb/tb_plic_irq_axil_forwarder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_irq_axil_forwarder.sv
// Mirrors PLIC interrupt levels to per-target AXI-lite doorbells at base_addr_p + t*stride_p.
// Latency: irq_i edge to awvalid is 1 cycle, or 3 with PLIC_IRQ_FWD_SYNC_EN defined (2-flop input synchroniser).
// Backpressure: one write in flight; AW/W hold until each handshakes; error responses retried up to max_retry_p times.
module plic_irq_axil_forwarder #(
  parameter int unsigned targets_p         = 2,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned axil_addr_width_p = 32,
  parameter logic [63:0] base_addr_p       = 64'h30_a000,
  parameter logic [63:0] stride_p          = 64'h1000,
  parameter int unsigned max_retry_p       = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [targets_p-1:0]             irq_i,
  output logic [axil_addr_width_p-1:0]     m_axil_awaddr_o,
  output logic [2:0]                       m_axil_awprot_o,
  output logic                             m_axil_awvalid_o,
  input  logic                             m_axil_awready_i,
  output logic [axil_data_width_p-1:0]     m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0]   m_axil_wstrb_o,
  output logic                             m_axil_wvalid_o,
  input  logic                             m_axil_wready_i,
  input  logic [1:0]                       m_axil_bresp_i,
  input  logic                             m_axil_bvalid_i,
  output logic                             m_axil_bready_o,
  output logic                             busy_o,
  output logic [targets_p-1:0]             err_o
);

  localparam int unsigned GW = (targets_p > 1) ? $clog2(targets_p) : 1;
  localparam int unsigned AW = axil_addr_width_p;
  localparam int unsigned DW = axil_data_width_p;
  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic [targets_p-1:0] r_sent;
  logic [targets_p-1:0] r_err;
  logic [GW-1:0]        r_ptr;
  logic [GW-1:0]        r_grant;
  logic                 r_v;
  logic [AW-1:0]        r_awaddr;
  logic                 r_awvalid;
  logic                 r_wvalid;
  logic                 r_bready;
  logic                 r_busy;
  logic [RW-1:0]        r_retry;

  logic [targets_p-1:0] w_irq_s;
  logic [targets_p-1:0] w_pend;
  logic                 w_any;
  logic [GW-1:0]        w_grant;
  logic [GW-1:0]        w_ptr_nxt;
  logic [AW-1:0]        w_addr;
  logic                 w_aw_done;
  logic                 w_w_done;
  logic                 w_bresp_err;

`ifdef PLIC_IRQ_FWD_SYNC_EN
  logic [targets_p-1:0] r_sync1;
  logic [targets_p-1:0] r_sync2;

  // Two-flop synchroniser per interrupt bit for levels from another clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq_i;
`endif

  // A target needs a write whenever its level differs from the last level delivered.
  assign w_pend = w_irq_s ^ r_sent;

  // Round-robin pick: first pending target at or after the pointer, wrapping.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int i = 0; i < int'(targets_p); i++) begin
      if (!w_any && w_pend[(int'(r_ptr) + i) % int'(targets_p)]) begin
        w_any   = 1'b1;
        w_grant = GW'((int'(r_ptr) + i) % int'(targets_p));
      end
    end
  end

  assign w_ptr_nxt   = (w_grant == GW'(targets_p - 1)) ? '0 : w_grant + 1'b1;
  // Doorbell address wraps modulo the address width by truncation.
  assign w_addr      = AW'(base_addr_p) + AW'(w_grant) * AW'(stride_p);
  assign w_aw_done   = !r_awvalid || m_axil_awready_i;
  assign w_w_done    = !r_wvalid  || m_axil_wready_i;
  assign w_bresp_err = (m_axil_bresp_i == 2'b10) || (m_axil_bresp_i == 2'b11);

  // Main control: grant, independent AW/W handshakes, response handling with bounded retry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_sent    <= '0;
      r_err     <= '0;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_v       <= 1'b0;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_busy    <= 1'b0;
      r_retry   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant   <= w_grant;
            r_v       <= w_irq_s[w_grant];
            r_awaddr  <= w_addr;
            r_ptr     <= w_ptr_nxt;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            if (r_awvalid && m_axil_awready_i) r_awvalid <= 1'b0;
            if (r_wvalid && m_axil_wready_i)   r_wvalid  <= 1'b0;
          end
        end
        ST_RESP: begin
          if (m_axil_bvalid_i) begin
            r_bready <= 1'b0;
            if (w_bresp_err && (r_retry < RW'(max_retry_p))) begin
              // Resend the same address/data; both were held in their registers.
              r_retry   <= r_retry + 1'b1;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_SEND;
            end else begin
              // Success, or retries exhausted: either way the level counts as delivered.
              if (w_bresp_err) r_err[r_grant] <= 1'b1;
              r_sent[r_grant] <= r_v;
              r_retry         <= '0;
              r_busy          <= 1'b0;
              r_state         <= ST_IDLE;
            end
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axil_awaddr_o  = r_awaddr;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = r_awvalid;
  assign m_axil_wdata_o   = {{(DW-1){1'b0}}, r_v};
  assign m_axil_wstrb_o   = '1;
  assign m_axil_wvalid_o  = r_wvalid;
  assign m_axil_bready_o  = r_bready;
  assign busy_o           = r_busy;
  assign err_o            = r_err;

endmodule

// File: tb/tb_plic_irq_axil_forwarder.sv
// Bench for plic_irq_axil_forwarder: 3 targets, max_retry_p = 3.
// A transaction-level model predicts bus outputs each cycle; directed cases pin literal values.
// The AXI slave answers every bready with bvalid one cycle later; bresp chosen per test.
module tb_plic_irq_axil_forwarder;
  localparam int N     = 3;
  localparam int MAXR  = 3;
  localparam logic [31:0] BASE   = 32'h30_a000;
  localparam logic [31:0] STRIDE = 32'h1000;
`ifdef PLIC_IRQ_FWD_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  irq;
  logic [31:0]   awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic          busy;
  logic [N-1:0]  err;

  always #5 clk = ~clk;

  plic_irq_axil_forwarder #(
    .targets_p(N), .axil_data_width_p(32), .axil_addr_width_p(32),
    .base_addr_p(64'h30_a000), .stride_p(64'h1000), .max_retry_p(MAXR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .irq_i(irq),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready), .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
    .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready), .m_axil_bresp_i(bresp),
    .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready), .busy_o(busy), .err_o(err)
  );

  // ---------------- slave responder ----------------
  int         b_seen = 0;
  int         b_err_target = 0;
  logic [1:0] b_err_code = 2'b10;
  logic [1:0] b_ok_code  = 2'b00;

  always @(posedge clk) begin
    if (bvalid && bready) b_seen++;
    #1;
    bvalid = bready;
    bresp  = (b_seen < b_err_target) ? b_err_code : b_ok_code;
  end

  // ---------------- write log ----------------
  logic [31:0] q_aw[$];
  logic [31:0] q_w[$];

  always @(posedge clk) begin
    if (rst_ni) begin
      if (awvalid && awready) q_aw.push_back(awaddr);
      if (wvalid && wready)   q_w.push_back(wdata);
    end
  end

  // ---------------- transaction model ----------------
  // A change is "delivered" once its write gets a final response; the
  // model keeps the per-target delivered level and the next RR start.
  int          m_sent[N];
  int          m_ptr;
  int          m_g;
  int          m_v;
  int          m_tries;
  bit          m_inflight, m_aw, m_w, m_b, m_found;
  logic [N-1:0] m_err;
  logic [31:0] m_addr;
  logic [N-1:0] m_lvl, m_s1, m_s2;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_inflight = 0; m_aw = 0; m_w = 0; m_b = 0;
      m_tries = 0; m_ptr = 0; m_g = 0; m_v = 0; m_addr = 0;
      m_err = '0; m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int k = 0; k < N; k++) m_sent[k] = 0;
    end else begin
`ifdef PLIC_IRQ_FWD_SYNC_EN
      m_lvl = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
      m_lvl = irq;
`endif
      if (!m_inflight) begin
        m_found = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && (int'(m_lvl[(m_ptr + k) % N]) != m_sent[(m_ptr + k) % N])) begin
            m_found = 1;
            m_g = (m_ptr + k) % N;
          end
        end
        if (m_found) begin
          m_v = int'(m_lvl[m_g]);
          m_addr = BASE + STRIDE * m_g;
          m_ptr = (m_g + 1) % N;
          m_inflight = 1; m_aw = 1; m_w = 1; m_b = 0;
        end
      end else if (m_aw || m_w) begin
        if (m_aw && awready) m_aw = 0;
        if (m_w && wready)   m_w = 0;
        if (!m_aw && !m_w)   m_b = 1;
      end else if (m_b && bvalid) begin
        m_b = 0;
        if (bresp[1] && m_tries < MAXR) begin
          m_tries++; m_aw = 1; m_w = 1;
        end else begin
          if (bresp[1]) m_err[m_g] = 1'b1;
          m_sent[m_g] = m_v;
          m_tries = 0;
          m_inflight = 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_awvalid", awvalid, m_aw);
    chk("m_wvalid", wvalid, m_w);
    chk("m_bready", bready, m_b);
    chk("m_busy", busy, m_inflight);
    chk("m_err", err, m_err);
    chk("m_awprot", awprot, 0);
    chk("m_wstrb", wstrb, 4'hf);
    if (m_aw) chk("m_awaddr", awaddr, m_addr);
    if (m_w)  chk("m_wdata", wdata, m_v);
  endtask

  // One cycle: compare on the falling edge, return just after the next rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst_ni) cmp_model();
      @(posedge clk);
      #1;
    end
  endtask

  int s_aw, s_w, s_b;

  initial begin
    rst_ni = 1'b0; irq = '0; awready = 1'b1; wready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_ni = 1'b1;
    step(2);

    // Simultaneous rise on all targets: round-robin from target 0.
    s_aw = q_aw.size(); s_w = q_w.size();
    irq = 3'b111;
    step(LAT);
    chk("sim_first_addr", awaddr, 32'h30_a000);
    step(20);
    chk("sim_count", q_aw.size() - s_aw, 3);
    chk("sim_addr0", q_aw[s_aw], 32'h30_a000);
    chk("sim_addr1", q_aw[s_aw + 1], 32'h30_b000);
    chk("sim_addr2", q_aw[s_aw + 2], 32'h30_c000);
    chk("sim_data2", q_w[s_w + 2], 1);
    irq = 3'b000;
    step(20);
    chk("sim_fall_count", q_aw.size() - s_aw, 6);

    // Single rise then fall on target 0.
    s_aw = q_aw.size(); s_w = q_w.size();
    irq = 3'b001;
    chk("rise_pre_awvalid", awvalid, 0);
    step(LAT);
    chk("rise_awvalid", awvalid, 1);
    chk("rise_awaddr", awaddr, 32'h30_a000);
    chk("rise_wdata", wdata, 1);
    step(8);
    chk("rise_count", q_aw.size() - s_aw, 1);
    irq = 3'b000;
    step(8);
    chk("fall_count", q_aw.size() - s_aw, 2);
    chk("fall_addr", q_aw[s_aw + 1], 32'h30_a000);
    chk("fall_wdata", q_w[s_w + 1], 0);

    // Split handshake: W accepted first, AW held for three cycles; EXOKAY response.
    s_aw = q_aw.size(); s_w = q_w.size(); s_b = b_seen;
    b_ok_code = 2'b01;
    awready = 1'b0;
    irq = 3'b010;
    step(LAT);
    chk("split_both_valid", {awvalid, wvalid}, 2'b11);
    step(1);
    chk("split_w_dropped", {awvalid, wvalid}, 2'b10);
    chk("split_addr_hold", awaddr, 32'h30_b000);
    step(2);
    chk("split_aw_hold", {awvalid, wvalid, bready}, 3'b100);
    awready = 1'b1;
    step(1);
    chk("split_resp", {awvalid, bready}, 2'b01);
    step(6);
    chk("split_aw_count", q_aw.size() - s_aw, 1);
    chk("split_w_count", q_w.size() - s_w, 1);
    chk("split_b_count", b_seen - s_b, 1);
    b_ok_code = 2'b00;

    // Coalescing: 1-cycle pulse on target 1 and a toggle of target 0 during its flight.
    s_aw = q_aw.size(); s_w = q_w.size();
    awready = 1'b0;
    irq = 3'b011;
    step(LAT);
    chk("coal_addr", awaddr, 32'h30_a000);
    irq = 3'b001;
    step(1);
    irq = 3'b010;
    step(2);
    awready = 1'b1;
    step(12);
    chk("coal_count", q_aw.size() - s_aw, 2);
    chk("coal_addr1", q_aw[s_aw + 1], 32'h30_a000);
    chk("coal_data0", q_w[s_w], 1);
    chk("coal_data1", q_w[s_w + 1], 0);

    // Retry exhaustion: four SLVERR responses on target 0.
    s_aw = q_aw.size(); s_w = q_w.size(); s_b = b_seen;
    b_err_code = 2'b10;
    b_err_target = b_seen + 4;
    irq = 3'b011;
    step(24);
    chk("retry_count", q_aw.size() - s_aw, 4);
    chk("retry_addr3", q_aw[s_aw + 3], 32'h30_a000);
    chk("retry_data3", q_w[s_w + 3], 1);
    chk("retry_b", b_seen - s_b, 4);
    chk("retry_err", err, 3'b001);
    chk("retry_busy", busy, 0);
    step(6);
    chk("retry_no_more", q_aw.size() - s_aw, 4);

    // One DECERR then OKAY on target 1: resend succeeds, no new error flag.
    s_aw = q_aw.size(); s_w = q_w.size();
    b_err_code = 2'b11;
    b_err_target = b_seen + 1;
    irq = 3'b001;
    step(15);
    chk("decerr_count", q_aw.size() - s_aw, 2);
    chk("decerr_addr", q_aw[s_aw + 1], 32'h30_b000);
    chk("decerr_data", q_w[s_w + 1], 0);
    chk("decerr_err", err, 3'b001);

    // Reset in the middle of a write.
    awready = 1'b0;
    irq = 3'b011;
    step(LAT);
    chk("rstm_inflight", {awvalid, busy}, 2'b11);
    rst_ni = 1'b0;
    #1;
    chk("rstm_awvalid", awvalid, 0);
    chk("rstm_wvalid", wvalid, 0);
    chk("rstm_bready", bready, 0);
    chk("rstm_err", err, 0);
    irq = 3'b001;
    step(2);
    s_aw = q_aw.size();
    rst_ni = 1'b1;
    awready = 1'b1;
    step(LAT);
    chk("rstm_fresh_aw", awvalid, 1);
    chk("rstm_fresh_addr", awaddr, 32'h30_a000);
    chk("rstm_fresh_data", wdata, 1);
    step(8);
    chk("rstm_count", q_aw.size() - s_aw, 1);
    chk("rstm_err_clear", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
